// File: rtl/audio_frame_rd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_frame_rd_sched_if
// Brief    : FIFO read port and framed output stream bundle for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_frame_rd_sched_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int LEVEL_WIDTH = 12
);
    logic                   fifo_rd_en;
    logic [DATA_WIDTH-1:0]  fifo_rd_data;
    logic                   fifo_rd_empty;
    logic [LEVEL_WIDTH-1:0] fifo_rd_water_level;
    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_sop;
    logic                   m_eop;

    modport master (
        output fifo_rd_en, m_data, m_valid, m_sop, m_eop,
        input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid, m_sop, m_eop,
        output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, m_ready
    );
endinterface
`default_nettype wire

// File: rtl/audio_frame_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : audio_frame_rd_sched
// Brief    : Pulls whole audio frames from the async FIFO read side and streams
//            them out with sop/eop. Optional statistics: AUDIO_FRM_SCHED_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_frame_rd_sched #(
    parameter int DATA_WIDTH  = 16,
    parameter int LEVEL_WIDTH = 12,
    parameter int FRAME_LEN   = 256,
    parameter int CNT_WIDTH   = 11
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    sched_en,
    audio_frame_rd_sched_if.master bus,
    output logic                   busy,
    output logic                   frame_done
`ifdef AUDIO_FRM_SCHED_STAT_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic                   stall_flag
`endif
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   c_frame_len  = CNT_WIDTH'(FRAME_LEN);
    localparam logic [CNT_WIDTH-1:0]   c_frame_last = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [LEVEL_WIDTH-1:0] c_level_min  = LEVEL_WIDTH'(FRAME_LEN);

    state_t                 state_q, state_d;
    logic                   level_ok_q;
    logic [CNT_WIDTH-1:0]   issued_q, issued_d;
    logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic [1:0]             occ_q, occ_d;
    logic                   inflight_q;
    logic [DATA_WIDTH-1:0]  buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0]  buf1_q, buf1_d;
    logic                   frame_done_q;

    logic                   w_rd;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_last;
    logic [2:0]             w_load;

    assign w_valid = (occ_q != 2'd0);
    assign w_pop   = w_valid && bus.m_ready;
    assign w_last  = (out_cnt_q == c_frame_last);
    // Slots already committed: buffered samples plus the read still in flight.
    assign w_load  = {1'b0, occ_q} + {2'b00, inflight_q};

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        w_rd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                issued_d = '0;
                if (level_ok_q) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                w_rd = !bus.fifo_rd_empty && (issued_q < c_frame_len) &&
                       (w_load < (3'd2 + {2'b00, w_pop}));
                if (w_rd) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_q == c_frame_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // buf0 is the head presented downstream; buf1 only fills behind it.
    always_comb begin
        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({inflight_q, w_pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = bus.fifo_rd_data;
                end else begin
                    buf1_d = bus.fifo_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = bus.fifo_rd_data;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = bus.fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (w_pop) begin
            out_cnt_d = w_last ? '0 : out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            level_ok_q   <= 1'b0;
            issued_q     <= '0;
            out_cnt_q    <= '0;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_ok_q   <= sched_en && (bus.fifo_rd_water_level >= c_level_min);
            issued_q     <= issued_d;
            out_cnt_q    <= out_cnt_d;
            occ_q        <= occ_d;
            inflight_q   <= w_rd;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            frame_done_q <= w_pop && w_last;
        end
    end

    assign bus.fifo_rd_en = w_rd;
    assign bus.m_data     = buf0_q;
    assign bus.m_valid    = w_valid;
    assign bus.m_sop      = w_valid && (out_cnt_q == '0);
    assign bus.m_eop      = w_valid && w_last;
    assign busy           = (state_q != S_IDLE);
    assign frame_done     = frame_done_q;

`ifdef AUDIO_FRM_SCHED_STAT_EN
    logic [15:0] frame_cnt_q;
    logic        stall_flag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= 16'd0;
            stall_flag_q <= 1'b0;
        end else begin
            if (frame_done_q) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if ((state_q == S_BURST) && bus.fifo_rd_empty && (issued_q < c_frame_len)) begin
                stall_flag_q <= 1'b1;
            end
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign stall_flag = stall_flag_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_audio_frame_rd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_frame_rd_sched
// Brief    : Scoreboard bench: FIFO model feeds the scheduler, monitor checks
//            every accepted beat, framing, frame_done and read-enable rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_frame_rd_sched;
    localparam int FRAME_LEN = 256;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sched_en = 1'b0;
    logic busy;
    logic frame_done;
`ifdef AUDIO_FRM_SCHED_STAT_EN
    logic [15:0] frame_cnt;
    logic        stall_flag;
`endif

    logic        force_empty = 1'b0;
    logic        rdy_toggle  = 1'b0;
    logic        rdy_ph      = 1'b0;
    logic [15:0] q[$];
    exp_t        sb[$];
    logic [15:0] next_val = 16'h1000;
    int          ld_idx = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, rd_total = 0, beats_total = 0, frames_done = 0, gap_rd = 0;
    int outstanding = 0, sop_cyc = 0, eop_cyc = 0;
    logic exp_done = 1'b0, hold_prev = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
    logic [15:0] prev_data = 16'h0;

    audio_frame_rd_sched_if #(.DATA_WIDTH(16), .LEVEL_WIDTH(12)) bus ();

    audio_frame_rd_sched #(
        .DATA_WIDTH (16),
        .LEVEL_WIDTH(12),
        .FRAME_LEN  (FRAME_LEN),
        .CNT_WIDTH  (11)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sched_en  (sched_en),
        .bus       (bus),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef AUDIO_FRM_SCHED_STAT_EN
        ,
        .frame_cnt (frame_cnt),
        .stall_flag(stall_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: registered read data, level/empty refreshed mid low phase.
    always @(posedge clk) begin
        if (rst_n && bus.fifo_rd_en && (q.size() > 0)) begin
            bus.fifo_rd_data <= q.pop_front();
        end
    end

    always @(negedge clk) begin
        #1;
        bus.fifo_rd_water_level = 12'(q.size());
        bus.fifo_rd_empty       = (q.size() == 0) || force_empty;
    end

    always @(negedge clk) begin
        rdy_ph      = ~rdy_ph;
        bus.m_ready = rdy_toggle ? rdy_ph : 1'b1;
    end

    // Monitor: samples between negedge and posedge when all signals are stable.
    always @(negedge clk) begin
        exp_t e;
        #2;
        cyc++;
        if (!rst_n) begin
            exp_done    = 1'b0;
            hold_prev   = 1'b0;
            outstanding = 0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            if (exp_done) frames_done++;
            exp_done = 1'b0;
            if (hold_prev) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", 32'(bus.m_data), 32'(prev_data));
                chk("hold_sop", 32'(bus.m_sop), 32'(prev_sop));
                chk("hold_eop", 32'(bus.m_eop), 32'(prev_eop));
            end
            if (bus.fifo_rd_en) begin
                rd_total++;
                outstanding++;
                chk("rd_while_empty", 32'(bus.fifo_rd_empty), 32'd0);
                if (force_empty) gap_rd++;
            end
            if (bus.m_valid && bus.m_ready) begin
                beats_total++;
                outstanding--;
                if (sb.size() == 0) begin
                    chk("beat_expected", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(bus.m_data), 32'(e.d));
                    chk("beat_sop", 32'(bus.m_sop), 32'(e.sop));
                    chk("beat_eop", 32'(bus.m_eop), 32'(e.eop));
                    if (e.sop) sop_cyc = cyc;
                    if (e.eop) begin
                        eop_cyc  = cyc;
                        exp_done = 1'b1;
                    end
                end
            end
            if (bus.fifo_rd_en || bus.m_valid) begin
                chk("occupancy_le_2", 32'(outstanding <= 2), 32'd1);
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            prev_sop  = bus.m_sop;
            prev_eop  = bus.m_eop;
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic load(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            q.push_back(next_val);
            sb.push_back('{d: next_val, sop: (ld_idx % FRAME_LEN) == 0,
                           eop: (ld_idx % FRAME_LEN) == FRAME_LEN - 1});
            next_val++;
            ld_idx++;
        end
    endtask

    task automatic flush();
        q.delete();
        sb.delete();
        ld_idx = 0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        for (int i = 0; i < limit && frames_done < target; i++) tick();
        chk("frames_done", 32'(frames_done), 32'(target));
    endtask

    task automatic wait_beats(input int target);
        for (int i = 0; i < 2000 && beats_total < target; i++) tick();
        chk("reach_beats", 32'(beats_total >= target), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
        chk({tag, "_sop"}, 32'(bus.m_sop), 32'd0);
        chk({tag, "_eop"}, 32'(bus.m_eop), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_data"}, 32'(bus.m_data), 32'd0);
`ifdef AUDIO_FRM_SCHED_STAT_EN
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_stall_flag"}, 32'(stall_flag), 32'd0);
`endif
    endtask

    initial begin
        int base_rd, base_beats;

        tick();
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_outputs_zero("post_reset");

        // Level 255 must not start a frame; 256 starts one.
        load(255);
        sched_en = 1'b1;
        repeat (5) tick();
        chk("idle_at_255", 32'(busy), 32'd0);
        base_rd = rd_total;
        load(1);
        tick();
        chk("idle_while_registering", 32'(busy), 32'd0);
        tick();
        chk("burst_entered", 32'(busy), 32'd1);
        chk("first_rd_en", 32'(bus.fifo_rd_en), 32'd1);
        tick();
        chk("valid_latency_1", 32'(bus.m_valid), 32'd0);
        tick();
        chk("valid_latency_2", 32'(bus.m_valid), 32'd1);
        chk("first_sop", 32'(bus.m_sop), 32'd1);
        wait_frames(1, 600);
        repeat (3) tick();
        chk("t1_rd_pulses", 32'(rd_total - base_rd), 32'd256);
        chk("t1_beats_consecutive", 32'(eop_cyc - sop_cyc), 32'd255);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Level 1024 with m_ready toggling; stop after the second frame.
        load(1024);
        rdy_toggle = 1'b1;
        wait_frames(2, 1500);
        @(negedge clk);
        sched_en = 1'b0;
        wait_frames(3, 1500);
        repeat (20) tick();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_remaining", 32'(sb.size()), 32'd512);
`ifdef AUDIO_FRM_SCHED_STAT_EN
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("t2_no_stall", 32'(stall_flag), 32'd0);
`endif
        flush();
        rdy_toggle = 1'b0;

        // FIFO empty gap of 20 cycles after sample 100.
        load(256);
        sched_en = 1'b1;
        base_rd  = rd_total;
        for (int i = 0; i < 500 && (rd_total - base_rd) < 100; i++) tick();
        @(negedge clk);
        force_empty = 1'b1;
        gap_rd = 0;
        repeat (20) @(negedge clk);
        force_empty = 1'b0;
        wait_frames(4, 800);
        repeat (3) tick();
        chk("t3_gap_reads", 32'(gap_rd), 32'd0);
        chk("t3_rd_pulses", 32'(rd_total - base_rd), 32'd256);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
`ifdef AUDIO_FRM_SCHED_STAT_EN
        chk("t3_stall_flag", 32'(stall_flag), 32'd1);
`endif

        // sched_en dropped at sample 50 with level 600.
        load(600);
        base_rd    = rd_total;
        base_beats = beats_total;
        wait_beats(base_beats + 50);
        @(negedge clk);
        sched_en = 1'b0;
        wait_frames(5, 800);
        repeat (20) tick();
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_remaining", 32'(sb.size()), 32'd344);
        chk("t4_rd_pulses", 32'(rd_total - base_rd), 32'd256);
`ifdef AUDIO_FRM_SCHED_STAT_EN
        chk("t4_stall_sticky", 32'(stall_flag), 32'd1);
`endif
        flush();

        // Asynchronous reset mid-burst at sample 120.
        load(300);
        sched_en   = 1'b1;
        base_beats = beats_total;
        wait_beats(base_beats + 120);
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        chk_outputs_zero("mid_reset");
        flush();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_outputs_zero("after_mid_reset");
        load(256);
        wait_frames(6, 800);
        repeat (3) tick();
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
`ifdef AUDIO_FRM_SCHED_STAT_EN
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t5_stall_cleared", 32'(stall_flag), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
